// File: rtl/vector_processor_core.sv
// rtl/vector_processor_core.sv - single-cycle 4x8-bit SIMD execute core with 16-entry vector register file
module vector_processor_core (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ID_VS,
  input  logic [4:0]  ID_VT,
  input  logic [4:0]  ID_VD,
  input  logic [11:0] ID_SHAMT,
  input  logic [4:0]  ID_OP,
  input  logic [15:0] ID_IMM16,
  input  logic [31:0] register_mov_data,
  input  logic [31:0] data_memory_direction,
  input  logic [31:0] data_load_mem,
  output logic        mem_write_en,
  output logic [31:0] mem_address,
  output logic [31:0] data_store_mem,
  output logic [31:0] result_out,
  output logic        result_valid
);

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_XOR   = 5'b00011;
  localparam logic [4:0] OP_MOV   = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SLL   = 5'b00110;
  localparam logic [4:0] OP_SRL   = 5'b00111;
  localparam logic [4:0] OP_LOAD  = 5'b01000;
  localparam logic [4:0] OP_STORE = 5'b01001;

  logic [31:0] regs_q [16];
  logic [31:0] regs_d [16];
  logic        mem_write_en_q, mem_write_en_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] data_store_mem_q, data_store_mem_d;
  logic [31:0] result_out_q, result_out_d;
  logic        result_valid_q, result_valid_d;

  // Only the low shift/immediate bits carry meaning; the rest are ignored.
  logic        unused_bits;
  assign unused_bits = ^{ID_SHAMT[11:3], ID_IMM16[15:8]};

  logic [2:0]  shamt3;
  logic [7:0]  imm8;
  logic [31:0] op_a, op_b;
  assign shamt3 = ID_SHAMT[2:0];
  assign imm8   = ID_IMM16[7:0];

  // Scalar source fields read as zero; vector fields read the pre-edge register value.
  assign op_a = ID_VS[4] ? regs_q[ID_VS[3:0]] : 32'h0;
  assign op_b = ID_VT[4] ? regs_q[ID_VT[3:0]] : 32'h0;

  logic [31:0] sub_v, add_v, xor_v, addi_v, sll_v, srl_v;

  // Each lane is computed in isolation so no carry/borrow or shifted bit crosses lanes.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign sub_v[8*k +: 8]  = op_a[8*k +: 8] - op_b[8*k +: 8];
    assign add_v[8*k +: 8]  = op_a[8*k +: 8] + op_b[8*k +: 8];
    assign xor_v[8*k +: 8]  = op_a[8*k +: 8] ^ op_b[8*k +: 8];
    assign addi_v[8*k +: 8] = op_a[8*k +: 8] + imm8;
    assign sll_v[8*k +: 8]  = op_a[8*k +: 8] << shamt3;
    assign srl_v[8*k +: 8]  = op_a[8*k +: 8] >> shamt3;
  end

  logic [31:0] alu_result;
  logic        op_writes;
  logic        op_store;

  // Opcode decode: pick the result and whether the op writes back or stores.
  always_comb begin
    alu_result = 32'h0;
    op_writes  = 1'b0;
    op_store   = 1'b0;
    case (ID_OP)
      OP_SUB:   begin alu_result = sub_v;             op_writes = 1'b1; end
      OP_ADD:   begin alu_result = add_v;             op_writes = 1'b1; end
      OP_XOR:   begin alu_result = xor_v;             op_writes = 1'b1; end
      OP_MOV:   begin alu_result = register_mov_data; op_writes = 1'b1; end
      OP_ADDI:  begin alu_result = addi_v;            op_writes = 1'b1; end
      OP_SLL:   begin alu_result = sll_v;             op_writes = 1'b1; end
      OP_SRL:   begin alu_result = srl_v;             op_writes = 1'b1; end
      OP_LOAD:  begin alu_result = data_load_mem;     op_writes = 1'b1; end
      OP_STORE: op_store = 1'b1;
      OP_NOP:   ;
      default:  ;
    endcase
  end

  logic reg_write;
  assign reg_write = op_writes & ID_VD[4];

  // Next-state for the register file and the store/result interface.
  always_comb begin
    regs_d           = regs_q;
    result_out_d     = result_out_q;
    result_valid_d   = reg_write;
    mem_write_en_d   = op_store;
    mem_address_d    = mem_address_q;
    data_store_mem_d = data_store_mem_q;
    if (reg_write) begin
      regs_d[ID_VD[3:0]] = alu_result;
      result_out_d       = alu_result;
    end
    if (op_store) begin
      mem_address_d    = data_memory_direction;
      data_store_mem_d = op_a;
    end
  end

  // State register; reset wins over any write on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= 32'h0;
      end
      mem_write_en_q   <= 1'b0;
      mem_address_q    <= 32'h0;
      data_store_mem_q <= 32'h0;
      result_out_q     <= 32'h0;
      result_valid_q   <= 1'b0;
    end else begin
      regs_q           <= regs_d;
      mem_write_en_q   <= mem_write_en_d;
      mem_address_q    <= mem_address_d;
      data_store_mem_q <= data_store_mem_d;
      result_out_q     <= result_out_d;
      result_valid_q   <= result_valid_d;
    end
  end

  assign mem_write_en   = mem_write_en_q;
  assign mem_address    = mem_address_q;
  assign data_store_mem = data_store_mem_q;
  assign result_out     = result_out_q;
  assign result_valid   = result_valid_q;

endmodule

// File: tb/tb_vector_processor_core.sv
// tb/tb_vector_processor_core.sv - self-checking bench for vector_processor_core
module tb_vector_processor_core;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  ID_VS, ID_VT, ID_VD, ID_OP;
  logic [11:0] ID_SHAMT;
  logic [15:0] ID_IMM16;
  logic [31:0] register_mov_data, data_memory_direction, data_load_mem;
  logic        mem_write_en, result_valid;
  logic [31:0] mem_address, data_store_mem, result_out;

  vector_processor_core dut (
    .clock(clock), .reset(reset),
    .ID_VS(ID_VS), .ID_VT(ID_VT), .ID_VD(ID_VD), .ID_SHAMT(ID_SHAMT),
    .ID_OP(ID_OP), .ID_IMM16(ID_IMM16),
    .register_mov_data(register_mov_data),
    .data_memory_direction(data_memory_direction),
    .data_load_mem(data_load_mem),
    .mem_write_en(mem_write_en), .mem_address(mem_address),
    .data_store_mem(data_store_mem), .result_out(result_out),
    .result_valid(result_valid)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] m_regs [16];
  logic [31:0] m_res, m_addr, m_store;
  logic        m_valid, m_we;

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  vs, vt, vd;
    logic [11:0] shamt;
    logic [15:0] imm;
    logic [31:0] data;
    logic [31:0] addr;
    logic [31:0] exp_res;
    logic        exp_valid;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input int s, input int imm);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < 4; i++) begin
      int x = int'(a[8*i +: 8]);
      int y = int'(b[8*i +: 8]);
      int z = 0;
      case (op)
        5'd1: z = (x - y + 256) % 256;
        5'd2: z = (x + y) % 256;
        5'd3: z = x ^ y;
        5'd5: z = (x + imm) % 256;
        5'd6: z = (x * (1 << s)) % 256;
        5'd7: z = x / (1 << s);
        default: z = 0;
      endcase
      r[8*i +: 8] = z[7:0];
    end
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    m_res = 0; m_addr = 0; m_store = 0; m_valid = 0; m_we = 0;
  endfunction

  function automatic void model_step(input vec_t v);
    logic [31:0] a, b, r;
    bit writes;
    a = v.vs[4] ? m_regs[v.vs[3:0]] : 32'h0;
    b = v.vt[4] ? m_regs[v.vt[3:0]] : 32'h0;
    writes = (v.op >= 5'd1 && v.op <= 5'd8);
    if (v.op == 5'd4 || v.op == 5'd8) r = v.data;
    else r = lanes(v.op, a, b, int'(v.shamt[2:0]), int'(v.imm[7:0]));
    m_valid = writes && v.vd[4];
    if (m_valid) begin
      m_regs[v.vd[3:0]] = r;
      m_res = r;
    end
    m_we = (v.op == 5'd9);
    if (m_we) begin
      m_addr = v.addr;
      m_store = a;
    end
  endfunction

  task automatic drive(input vec_t v);
    ID_OP = v.op; ID_VS = v.vs; ID_VT = v.vt; ID_VD = v.vd;
    ID_SHAMT = v.shamt; ID_IMM16 = v.imm;
    register_mov_data = v.data; data_load_mem = v.data;
    data_memory_direction = v.addr;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".result_out"}, result_out, m_res);
    chk({tag, ".result_valid"}, 32'(result_valid), 32'(m_valid));
    chk({tag, ".mem_write_en"}, 32'(mem_write_en), 32'(m_we));
    chk({tag, ".mem_address"}, mem_address, m_addr);
    chk({tag, ".data_store_mem"}, data_store_mem, m_store);
  endtask

  task automatic exec(input vec_t v, input string tag);
    @(negedge clock);
    drive(v);
    @(posedge clock);
    model_step(v);
    #1;
    check_model(tag);
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [4:0] vs, input logic [4:0] vt,
                              input logic [4:0] vd, input logic [11:0] sh, input logic [15:0] imm,
                              input logic [31:0] data, input logic [31:0] addr,
                              input logic [31:0] er, input logic ev);
    vec_t v;
    v.op = op; v.vs = vs; v.vt = vt; v.vd = vd; v.shamt = sh; v.imm = imm;
    v.data = data; v.addr = addr; v.exp_res = er; v.exp_valid = ev;
    return v;
  endfunction

  vec_t tbl [$];
  vec_t v;

  initial begin
    reset = 1'b1;
    v = mk(5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
    model_reset();

    // Directed vectors: register fields use bit4=1 for V-registers.
    tbl.push_back(mk(5'd4, 5'h00, 5'h00, 5'h10, 0, 0, 32'h00010203, 0, 32'h00010203, 1));
    tbl.push_back(mk(5'd4, 5'h00, 5'h00, 5'h11, 0, 0, 32'h04050607, 0, 32'h04050607, 1));
    tbl.push_back(mk(5'd2, 5'h10, 5'h11, 5'h14, 0, 0, 0, 0, 32'h0406080A, 1));
    tbl.push_back(mk(5'd4, 5'h00, 5'h00, 5'h12, 0, 0, 32'hFF80017F, 0, 32'hFF80017F, 1));
    tbl.push_back(mk(5'd2, 5'h12, 5'h12, 5'h13, 0, 0, 0, 0, 32'hFE0002FE, 1));
    tbl.push_back(mk(5'd4, 5'h00, 5'h00, 5'h17, 0, 0, 32'h00000000, 0, 32'h00000000, 1));
    tbl.push_back(mk(5'd4, 5'h00, 5'h00, 5'h18, 0, 0, 32'h01010101, 0, 32'h01010101, 1));
    tbl.push_back(mk(5'd1, 5'h17, 5'h18, 5'h19, 0, 0, 0, 0, 32'hFFFFFFFF, 1));
    tbl.push_back(mk(5'd4, 5'h00, 5'h00, 5'h1A, 0, 0, 32'h81818181, 0, 32'h81818181, 1));
    tbl.push_back(mk(5'd6, 5'h1A, 5'h00, 5'h1B, 12'hFF9, 0, 0, 0, 32'h02020202, 1));
    tbl.push_back(mk(5'd4, 5'h00, 5'h00, 5'h1C, 0, 0, 32'h80808080, 0, 32'h80808080, 1));
    tbl.push_back(mk(5'd7, 5'h1C, 5'h00, 5'h1D, 12'h007, 0, 0, 0, 32'h01010101, 1));
    tbl.push_back(mk(5'd4, 5'h00, 5'h00, 5'h1E, 0, 0, 32'h10203040, 0, 32'h10203040, 1));
    tbl.push_back(mk(5'd5, 5'h1E, 5'h00, 5'h1F, 0, 16'hAB05, 0, 0, 32'h15253545, 1));
    tbl.push_back(mk(5'd4, 5'h00, 5'h00, 5'h05, 0, 0, 32'hAAAAAAAA, 0, 32'h15253545, 0));
    tbl.push_back(mk(5'd9, 5'h15, 5'h00, 5'h00, 0, 0, 0, 32'h44, 32'h15253545, 0));
    tbl.push_back(mk(5'd2, 5'h00, 5'h1F, 5'h15, 0, 0, 0, 0, 32'h15253545, 1));
    tbl.push_back(mk(5'd15, 5'h1F, 5'h1F, 5'h15, 0, 0, 32'h12345678, 0, 32'h15253545, 0));
    tbl.push_back(mk(5'd8, 5'h00, 5'h00, 5'h16, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1));

    repeat (2) @(posedge clock);
    #1;
    check_model("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      exec(tbl[i], $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.exp_result", i), result_out, tbl[i].exp_res);
      chk($sformatf("vec%0d.exp_valid", i), 32'(result_valid), 32'(tbl[i].exp_valid));
    end
    // V5 must still be zero after the suppressed scalar-destination MOV
    chk("v5_untouched", data_store_mem, 32'h0);

    // STORE V6 at 0x100: one-cycle strobe, held address/data
    exec(mk(5'd9, 5'h16, 5'h00, 5'h00, 0, 0, 0, 32'h100, 0, 0), "store");
    chk("store.we", 32'(mem_write_en), 32'h1);
    chk("store.addr", mem_address, 32'h100);
    chk("store.data", data_store_mem, 32'hDEADBEEF);
    exec(mk(5'd0, 5'h16, 5'h00, 5'h10, 0, 0, 0, 32'h200, 0, 0), "after_store");
    chk("after_store.we", 32'(mem_write_en), 32'h0);
    chk("after_store.addr", mem_address, 32'h100);
    chk("after_store.data", data_store_mem, 32'hDEADBEEF);

    // Randomized instructions against the model
    for (int n = 0; n < 400; n++) begin
      v.op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
      v.vs = {($urandom_range(0, 4) != 0), 4'($urandom)};
      v.vt = {($urandom_range(0, 4) != 0), 4'($urandom)};
      v.vd = {($urandom_range(0, 4) != 0), 4'($urandom)};
      v.shamt = 12'($urandom);
      v.imm = 16'($urandom);
      v.data = $urandom;
      v.addr = $urandom;
      exec(v, $sformatf("rnd%0d", n));
    end

    // Read back every register through STORE
    for (int r = 0; r < 16; r++) begin
      exec(mk(5'd9, 5'(16 + r), 5'h00, 5'h00, 0, 0, 0, 32'(r), 0, 0), $sformatf("rdback%0d", r));
    end

    // Asynchronous reset between edges, overriding a write on the held edge
    @(posedge clock);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_model("async_reset");
    @(negedge clock);
    drive(mk(5'd4, 5'h00, 5'h00, 5'h14, 0, 0, 32'hCAFEF00D, 0, 0, 0));
    @(posedge clock);
    #1;
    check_model("reset_hold");
    @(negedge clock);
    reset = 1'b0;
    exec(mk(5'd2, 5'h10, 5'h11, 5'h14, 0, 0, 0, 0, 0, 0), "post_reset_add");
    chk("post_reset_add.result", result_out, 32'h0);
    chk("post_reset_add.valid", 32'(result_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
